// File: rtl/psram_sim_pkg.sv
// psram_sim_pkg: shared command codes, FSM states and parameter defaults for the octal PSRAM model
package psram_sim_pkg;
  localparam int MEM_AW_DEF = 12;
  localparam int RD_LATENCY_DEF = 4;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ = 8'h03;
  typedef enum logic [2:0] {CMD, ADDR_H, ADDR_M, ADDR_L, WDATA, RWAIT, RDATA, IGNORE} state_t;
endpackage

// File: rtl/psram_sim.sv
// psram_sim: octal SDR PSRAM device model with an internal byte array
module psram_sim
  import psram_sim_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input logic psram_sclk,
  input logic arst,
  input logic psram_csn,
  inout wire io_psram_data0,
  inout wire io_psram_data1,
  inout wire io_psram_data2,
  inout wire io_psram_data3,
  inout wire io_psram_data4,
  inout wire io_psram_data5,
  inout wire io_psram_data6,
  inout wire io_psram_data7
);
  logic [7:0] mem [2**MEM_AW] = '{default: 8'h00};
  state_t state, state_nx;
  logic rd_mode;
  logic [23:0] addr;
  logic [15:0] lat;
  logic [23:0] rcnt;
  logic [7:0] dout;
  logic oe, drive;
  logic [7:0] bus_in;
  logic [MEM_AW-1:0] rd_idx;
  assign bus_in = {io_psram_data7, io_psram_data6, io_psram_data5, io_psram_data4,
                   io_psram_data3, io_psram_data2, io_psram_data1, io_psram_data0};
  // read pointer is the burst base plus bytes already sent, wrapping at 24 bits before aliasing
  assign rd_idx = MEM_AW'(addr + rcnt);
  // csn high or reset releases the bus immediately, independent of the clock
  assign drive = oe & ~psram_csn & ~arst;
  assign io_psram_data0 = drive ? dout[0] : 1'bz;
  assign io_psram_data1 = drive ? dout[1] : 1'bz;
  assign io_psram_data2 = drive ? dout[2] : 1'bz;
  assign io_psram_data3 = drive ? dout[3] : 1'bz;
  assign io_psram_data4 = drive ? dout[4] : 1'bz;
  assign io_psram_data5 = drive ? dout[5] : 1'bz;
  assign io_psram_data6 = drive ? dout[6] : 1'bz;
  assign io_psram_data7 = drive ? dout[7] : 1'bz;
  // next-state decode; WDATA, RDATA and IGNORE hold until csn rises
  always_comb begin
    state_nx = state;
    case (state)
      CMD: state_nx = (bus_in == CMD_WRITE || bus_in == CMD_READ) ? ADDR_H : IGNORE;
      ADDR_H: state_nx = ADDR_M;
      ADDR_M: state_nx = ADDR_L;
      ADDR_L: state_nx = !rd_mode ? WDATA : (RD_LATENCY == 0) ? RDATA : RWAIT;
      RWAIT: state_nx = (lat == 16'(RD_LATENCY - 1)) ? RDATA : RWAIT;
      default: state_nx = state;
    endcase
  end
  // rising-edge control: command, address capture, write increment and dummy-cycle count
  always_ff @(posedge psram_sclk or posedge arst or posedge psram_csn)
    if (arst || psram_csn) begin
      state <= CMD;
      rd_mode <= 1'b0;
      addr <= '0;
      lat <= '0;
    end else begin
      state <= state_nx;
      if (state == CMD) rd_mode <= bus_in == CMD_READ;
      if (state == ADDR_H) addr[23:16] <= bus_in;
      if (state == ADDR_M) addr[15:8] <= bus_in;
      if (state == ADDR_L) addr[7:0] <= bus_in;
      if (state == WDATA) addr <= addr + 24'd1;
      lat <= (state == RWAIT) ? lat + 16'd1 : '0;
    end
  // memory is never reset so its contents survive arst
  always_ff @(posedge psram_sclk)
    if (state == WDATA) mem[addr[MEM_AW-1:0]] <= bus_in;
  // falling-edge read launch so each byte is stable at the controller's next rising edge
  always_ff @(negedge psram_sclk or posedge arst or posedge psram_csn)
    if (arst || psram_csn) begin
      oe <= 1'b0;
      rcnt <= '0;
      dout <= '0;
    end else if (state == RDATA) begin
      oe <= 1'b1;
      dout <= mem[rd_idx];
      rcnt <= rcnt + 24'd1;
    end else begin
      oe <= 1'b0;
      rcnt <= '0;
    end
endmodule

// File: tb/tb_psram_sim.sv
// tb_psram_sim: randomized self-checking bench for psram_sim against a flat byte-array model
module tb_psram_sim;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] csn = 2'b11;
  logic [1:0] en = 2'b00;
  logic [1:0][7:0] drv = '0;
  tri1 [7:0] bus_a;
  tri1 [7:0] bus_b;
  logic [7:0] model [2][4096];
  int errors = 0;
  int checks = 0;

  assign bus_a = en[0] ? drv[0] : 8'hzz;
  assign bus_b = en[1] ? drv[1] : 8'hzz;

  always #5 clk = ~clk;

  psram_sim u_a (
    .psram_sclk(clk), .arst(rst), .psram_csn(csn[0]),
    .io_psram_data0(bus_a[0]), .io_psram_data1(bus_a[1]), .io_psram_data2(bus_a[2]),
    .io_psram_data3(bus_a[3]), .io_psram_data4(bus_a[4]), .io_psram_data5(bus_a[5]),
    .io_psram_data6(bus_a[6]), .io_psram_data7(bus_a[7])
  );

  psram_sim #(.RD_LATENCY(0)) u_b (
    .psram_sclk(clk), .arst(rst), .psram_csn(csn[1]),
    .io_psram_data0(bus_b[0]), .io_psram_data1(bus_b[1]), .io_psram_data2(bus_b[2]),
    .io_psram_data3(bus_b[3]), .io_psram_data4(bus_b[4]), .io_psram_data5(bus_b[5]),
    .io_psram_data6(bus_b[6]), .io_psram_data7(bus_b[7])
  );

  function automatic logic [7:0] bus_of(input int s);
    return (s != 0) ? bus_b : bus_a;
  endfunction

  task automatic hdr(input int s, input logic [7:0] c, input logic [23:0] a);
    @(negedge clk); csn[s] = 1'b0; en[s] = 1'b1; drv[s] = c;
    for (int i = 2; i >= 0; i--) begin
      @(negedge clk); drv[s] = a[i*8 +: 8];
    end
  endtask

  task automatic wr(input int s, input logic [23:0] a, input logic [7:0] d[$]);
    hdr(s, 8'h02, a);
    foreach (d[i]) begin
      @(negedge clk); drv[s] = d[i];
      model[s][12'(a + 24'(i))] = d[i];
    end
    @(negedge clk); en[s] = 1'b0; csn[s] = 1'b1;
  endtask

  task automatic wr2(input int s, input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] q[$];
    q.push_back(b0);
    q.push_back(b1);
    wr(s, a, q);
  endtask

  task automatic rd_tail(input int s, input int n, output logic [7:0] q[$], output bit dz);
    q.delete();
    dz = 1'b1;
    @(negedge clk); en[s] = 1'b0;
    repeat ((s != 0) ? 0 : 4) begin
      #2; if (bus_of(s) !== 8'hff) dz = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      #2; q.push_back(bus_of(s));
      @(negedge clk);
    end
    csn[s] = 1'b1;
  endtask

  task automatic rd(input int s, input logic [23:0] a, input int n, output logic [7:0] q[$], output bit dz);
    hdr(s, 8'h03, a);
    rd_tail(s, n, q, dz);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (bus_a !== 8'hff) begin errors++; $display("FAIL reset_bus_a: got %h want ff", bus_a); end
    checks++;
    if (bus_b !== 8'hff) begin errors++; $display("FAIL reset_bus_b: got %h want ff", bus_b); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_write_read;
    logic [7:0] q[$];
    bit dz;
    wr2(0, 24'h040302, 8'h08, 8'h07);
    rd(0, 24'h040302, 2, q, dz);
    checks++;
    if (q[0] !== 8'h08) begin errors++; $display("FAIL wr_rd_byte0: got %h want 08", q[0]); end
    checks++;
    if (q[1] !== 8'h07) begin errors++; $display("FAIL wr_rd_byte1: got %h want 07", q[1]); end
    checks++;
    if (!dz) begin errors++; $display("FAIL wr_rd_dummy_z: bus driven during dummy cycles, want released"); end
    #2;
    checks++;
    if (bus_a !== 8'hff) begin errors++; $display("FAIL wr_rd_release: got %h want ff", bus_a); end
  endtask

  task automatic test_idle;
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      if (bus_a !== 8'hff || bus_b !== 8'hff) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_bus: got %0d driven samples want 0", bad); end
  endtask

  task automatic test_illegal;
    logic [7:0] q[$];
    logic [7:0] junk[6];
    bit dz;
    int bad = 0;
    junk = '{8'h04, 8'h03, 8'h02, 8'h55, 8'h66, 8'h77};
    @(negedge clk); csn[0] = 1'b0; en[0] = 1'b1; drv[0] = 8'hAA;
    foreach (junk[i]) begin
      @(negedge clk); drv[0] = junk[i];
    end
    @(negedge clk); en[0] = 1'b0;
    repeat (4) begin
      #2; if (bus_a !== 8'hff) bad++;
      @(negedge clk);
    end
    csn[0] = 1'b1;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL illegal_drive: got %0d driven samples want 0", bad); end
    rd(0, 24'h040302, 2, q, dz);
    checks++;
    if (q[0] !== 8'h08) begin errors++; $display("FAIL illegal_keep0: got %h want 08", q[0]); end
    checks++;
    if (q[1] !== 8'h07) begin errors++; $display("FAIL illegal_keep1: got %h want 07", q[1]); end
  endtask

  task automatic test_wrap;
    logic [7:0] q[$];
    bit dz;
    wr2(0, 24'h000FFF, 8'h11, 8'h22);
    rd(0, 24'h000FFF, 2, q, dz);
    checks++;
    if (q[0] !== 8'h11) begin errors++; $display("FAIL wrap_fff: got %h want 11", q[0]); end
    checks++;
    if (q[1] !== 8'h22) begin errors++; $display("FAIL wrap_000: got %h want 22", q[1]); end
    rd(0, 24'h000000, 1, q, dz);
    checks++;
    if (q[0] !== 8'h22) begin errors++; $display("FAIL wrap_direct0: got %h want 22", q[0]); end
    rd(0, 24'h123FFF, 2, q, dz);
    checks++;
    if (q[0] !== 8'h11 || q[1] !== 8'h22) begin
      errors++; $display("FAIL wrap_alias: got %h %h want 11 22", q[0], q[1]);
    end
    wr2(0, 24'hFFFFFF, 8'h33, 8'h44);
    rd(0, 24'h000000, 1, q, dz);
    checks++;
    if (q[0] !== 8'h44) begin errors++; $display("FAIL wrap_24bit: got %h want 44", q[0]); end
  endtask

  task automatic test_reset_mid_write;
    logic [7:0] q[$];
    logic [7:0] b0, b1, old1;
    logic [23:0] a;
    bit dz;
    a = 24'h000100;
    b0 = 8'($urandom);
    old1 = model[0][12'h101];
    b1 = ~old1;
    hdr(0, 8'h02, a);
    @(negedge clk); drv[0] = b0;
    model[0][12'h100] = b0;
    @(negedge clk); drv[0] = b1; rst = 1'b1;
    @(negedge clk); en[0] = 1'b0;
    #2;
    checks++;
    if (bus_a !== 8'hff) begin errors++; $display("FAIL rst_mid_bus: got %h want ff", bus_a); end
    @(negedge clk); rst = 1'b0; en[0] = 1'b1; drv[0] = 8'h03;
    for (int i = 2; i >= 0; i--) begin
      @(negedge clk); drv[0] = a[i*8 +: 8];
    end
    rd_tail(0, 2, q, dz);
    checks++;
    if (q[0] !== b0) begin errors++; $display("FAIL rst_mid_first: got %h want %h", q[0], b0); end
    checks++;
    if (q[1] !== old1) begin errors++; $display("FAIL rst_mid_second: got %h want %h", q[1], old1); end
  endtask

  task automatic test_latency0;
    logic [7:0] q[$];
    bit dz;
    wr2(1, 24'h040302, 8'h08, 8'h07);
    rd(1, 24'h040302, 2, q, dz);
    checks++;
    if (q[0] !== 8'h08) begin errors++; $display("FAIL lat0_byte0: got %h want 08", q[0]); end
    checks++;
    if (q[1] !== 8'h07) begin errors++; $display("FAIL lat0_byte1: got %h want 07", q[1]); end
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] d[$];
    logic [23:0] a;
    logic [7:0] exp;
    bit dz;
    int s, n;
    for (int t = 0; t < 60; t++) begin
      s = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 6));
      a[23:12] = 12'($urandom);
      a[11:0] = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 31)) : 12'(12'hFF0 + 12'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) != 0) begin
        d.delete();
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        wr(s, a, d);
      end else begin
        rd(s, a, n, q, dz);
        for (int i = 0; i < n; i++) begin
          exp = model[s][12'(a + 24'(i))];
          checks++;
          if (q[i] !== exp) begin
            errors++; $display("FAIL rand_read: inst %0d addr %h got %h want %h", s, a + 24'(i), q[i], exp);
          end
        end
        if (s == 0) begin
          checks++;
          if (!dz) begin errors++; $display("FAIL rand_dummy_z: addr %h bus driven during dummy cycles", a); end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4096; i++) model[s][i] = 8'h00;
    #1;
    test_reset;
    test_write_read;
    test_idle;
    test_illegal;
    test_wrap;
    test_reset_mid_write;
    test_latency0;
    test_random;
    test_idle;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psram_sim.md
PSRAM_SIM -- requirements
Module: psram_sim

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, giving the log2 of the byte depth of the internal array (4096 bytes).
REQ-002 SHALL have parameter RD_LATENCY, default 4, giving the number of dummy sclk cycles between the last address byte and the first read byte.
REQ-003 SHALL have port psram_sclk, input, 1 bit: the only clock, driven by the controller.
REQ-004 SHALL have port arst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port psram_csn, input, 1 bit: chip select, active-low.
REQ-006 SHALL have ports io_psram_data0..io_psram_data7, inout, 1 bit each, forming the octal bus; data0 is the LSB.

Function
REQ-007 SHALL use SDR transfers: sample the bus on psram_sclk rising edges and drive read data on falling edges.
REQ-008 SHALL keep all data lines high-Z, and the FSM in CMD, whenever psram_csn=1; csn rising SHALL abort any transaction asynchronously.
REQ-009 SHALL implement FSM states CMD, ADDR_H, ADDR_M, ADDR_L, WDATA, RWAIT, RDATA, IGNORE.
REQ-010 SHALL, in CMD on the first rising edge with csn=0, sample the command byte: 0x02 selects write, 0x03 selects read, and any other value selects IGNORE.
REQ-011 SHALL capture the 24-bit address MSB byte first in ADDR_H, ADDR_M and ADDR_L, on one rising edge each.
REQ-012 SHALL go from ADDR_L to WDATA for a write.
REQ-013 SHALL go from ADDR_L to RWAIT for a read, or directly to RDATA when RD_LATENCY=0.
REQ-014 SHALL, in WDATA on each rising edge, write the bus byte to mem[addr[MEM_AW-1:0]] and then increment addr.
REQ-015 SHALL write an unlimited number of bytes per burst, ending only on csn rising.
REQ-016 SHALL count RD_LATENCY rising edges in RWAIT and then enter RDATA.
REQ-017 SHALL, in RDATA on each falling edge, enable the bus and drive mem[addr[MEM_AW-1:0]], then increment addr.
REQ-018 SHALL make the first read byte valid at the next rising edge after RDATA is entered.
REQ-019 SHALL wrap the address modulo 2^24, and SHALL alias memory indexing onto the low MEM_AW bits (0xFFF+1 -> 0x000 for MEM_AW=12).
REQ-020 SHALL, in IGNORE, neither drive nor write until csn rises.
REQ-021 SHALL treat a partial address (csn rising before ADDR_L completes) as aborted, with no memory effect.
REQ-022 SHALL leave the bus undriven while a write byte is being sampled, so it never contends with the controller.
REQ-023 SHALL initialise all memory bytes to 0x00 at time zero.

Reset
REQ-024 SHALL, while arst=1 (asynchronously), force state=CMD, clear the address and latency counter, and release all data lines to high-Z.
REQ-025 SHALL leave memory contents unchanged on reset, so data survives reset.
REQ-026 SHALL, when reset is asserted mid-burst, leave bytes already written intact and discard the current byte.

Structure
REQ-027 SHALL place the command codes (CMD_WRITE=0x02, CMD_READ=0x03), the state enum and the parameter defaults in the shared package psram_sim_pkg.
REQ-028 SHALL be a single module with no sub-modules; the memory SHALL be an internal byte array.

Verification
REQ-029 SHALL cover write-then-read: write cmd 0x02, addr 0x040302, data 0x08,0x07, csn high; then read cmd 0x03 at the same address -> after 4 dummy cycles the bus returns 0x08 then 0x07.
REQ-030 SHALL cover an idle bus: csn=1 with sclk toggling -> all data lines Z, and memory unchanged.
REQ-031 SHALL cover an illegal command: cmd 0xAA followed by 6 bytes -> no drive and no memory change, and a later read of 0x040302 still returns the prior data.
REQ-032 SHALL cover wrap-around: write 0x11,0x22 at 0x000FFF -> mem[0xFFF]=0x11 and mem[0x000]=0x22.
REQ-033 SHALL cover reset mid-write: assert arst after the 1st data byte of a 2-byte write -> first byte stored, second not stored, bus Z, FSM in CMD.
REQ-034 SHALL cover RD_LATENCY=0: a read at 0x040302 drives 0x08 on the falling edge right after the ADDR_L rising edge.
